// File: rtl/eth_frame_gen.sv
// eth_frame_gen: Ethernet frame generator for MAC/PHY bring-up and loopback.
// Emits preamble, SFD, header, counting payload, FCS and inter-frame gap on an
// xMII-style interface DATA_W bits per beat, least-significant bits first.
// Optional macro: ETH_GEN_VLAN_EN inserts an 802.1Q tag after the source MAC.
// Handshake: start is a one-cycle request honoured only while idle (busy=0);
// busy stays high until the last IFG beat and done pulses as busy falls.
module eth_frame_gen #(
  parameter int          DATA_W    = 2,
  parameter int          IFG_BYTES = 12,
  parameter logic [47:0] DST_MAC   = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC   = 48'h000A35000001,
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter logic [11:0] VLAN_ID   = 12'd1
) (
  input  logic              clk_mac,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [15:0]       count,
  input  logic [10:0]       payload_len,
  input  logic [7:0]        seed,
  output logic              txen,
  output logic [DATA_W-1:0] txd,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frames_sent,
  output logic [2:0]        dbg_state
);

`ifdef ETH_GEN_VLAN_EN
  localparam int HDR_LEN = 18;
  localparam logic [10:0] MIN_LEN = 11'd42;
  localparam logic [HDR_LEN*8-1:0] HDR = {DST_MAC, SRC_MAC, 16'h8100, 4'h0, VLAN_ID, ETHERTYPE};
`else
  localparam int HDR_LEN = 14;
  localparam logic [10:0] MIN_LEN = 11'd46;
  localparam logic [HDR_LEN*8-1:0] HDR = {DST_MAC, SRC_MAC, ETHERTYPE};
`endif
  localparam int HDR_W = HDR_LEN * 8;
  localparam logic [1:0] LAST_BEAT = 2'(8 / DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_HDR, S_PAY, S_FCS, S_IFG
  } state_t;

  state_t      r_state;
  logic [10:0] r_idx;
  logic [1:0]  r_beat;
  logic [7:0]  r_sh;
  logic [31:0] r_crc;
  logic [15:0] r_count;
  logic [10:0] r_len;
  logic [7:0]  r_seed;
  logic        r_txen;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_frames;

  state_t      w_ns;
  logic [10:0] w_nidx;
  logic [7:0]  w_nbyte;
  logic [10:0] w_len_clamped;
  logic        w_count_done;
  logic [HDR_W-1:0] w_hdr_shl;
  logic [31:0] w_fcs_sh;

  // One byte of reflected CRC-32, bit-serial.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] x;
    x = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    end
    return x;
  endfunction

  assign w_len_clamped = (payload_len < MIN_LEN) ? MIN_LEN :
                         (payload_len > 11'd1500) ? 11'd1500 : payload_len;
  assign w_count_done  = (r_count != 16'd0) && (r_frames == r_count);
  assign w_hdr_shl     = HDR << (8 * (int'(r_idx[4:0]) + 1));
  assign w_fcs_sh      = (~r_crc) >> (8 * (int'(r_idx[1:0]) + 1));

  // Next state, byte index and byte value taken at a byte boundary.
  always_comb begin
    w_ns    = r_state;
    w_nidx  = r_idx + 11'd1;
    w_nbyte = 8'h00;
    case (r_state)
      S_PRE: begin
        if (r_idx == 11'd6) begin
          w_ns = S_SFD; w_nidx = 11'd0; w_nbyte = 8'hD5;
        end else begin
          w_nbyte = 8'h55;
        end
      end
      S_SFD: begin
        w_ns = S_HDR; w_nidx = 11'd0; w_nbyte = HDR[HDR_W-1 -: 8];
      end
      S_HDR: begin
        if (r_idx == 11'(HDR_LEN - 1)) begin
          w_ns = S_PAY; w_nidx = 11'd0; w_nbyte = r_seed;
        end else begin
          w_nbyte = w_hdr_shl[HDR_W-1 -: 8];
        end
      end
      S_PAY: begin
        if (r_idx == r_len - 11'd1) begin
          w_ns = S_FCS; w_nidx = 11'd0; w_nbyte = ~r_crc[7:0];
        end else begin
          w_nbyte = r_seed + r_idx[7:0] + 8'd1;
        end
      end
      S_FCS: begin
        if (r_idx == 11'd3) begin
          w_ns = S_IFG; w_nidx = 11'd0;
        end else begin
          w_nbyte = w_fcs_sh[7:0];
        end
      end
      S_IFG: begin
        if (r_idx == 11'(IFG_BYTES - 1)) begin
          w_nidx = 11'd0;
          if (stop || w_count_done) begin
            w_ns = S_IDLE;
          end else begin
            w_ns = S_PRE; w_nbyte = 8'h55;
          end
        end
      end
      default: begin
        w_ns = S_IDLE; w_nidx = 11'd0;
      end
    endcase
  end

  // Frame FSM, serializer, CRC and frame counter.
  always_ff @(posedge clk_mac) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= 11'd0;
      r_beat   <= 2'd0;
      r_sh     <= 8'h00;
      r_crc    <= 32'hFFFFFFFF;
      r_count  <= 16'd0;
      r_len    <= MIN_LEN;
      r_seed   <= 8'h00;
      r_txen   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_frames <= 16'd0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          r_count  <= count;
          r_len    <= w_len_clamped;
          r_seed   <= seed;
          r_frames <= 16'd0;
          r_state  <= S_PRE;
          r_idx    <= 11'd0;
          r_beat   <= 2'd0;
          r_sh     <= 8'h55;
          r_crc    <= 32'hFFFFFFFF;
          r_txen   <= 1'b1;
          r_busy   <= 1'b1;
        end
      end else if (r_beat != LAST_BEAT) begin
        r_beat <= r_beat + 2'd1;
        r_sh   <= r_sh >> DATA_W;
      end else begin
        r_beat  <= 2'd0;
        r_state <= w_ns;
        r_idx   <= w_nidx;
        r_sh    <= w_nbyte;
        r_txen  <= (w_ns != S_IFG) && (w_ns != S_IDLE);
        if (w_ns == S_HDR || w_ns == S_PAY) r_crc <= crc_byte(r_crc, w_nbyte);
        if (w_ns == S_PRE) r_crc <= 32'hFFFFFFFF;
        if (r_state == S_FCS && w_ns == S_IFG && r_frames != 16'hFFFF) begin
          r_frames <= r_frames + 16'd1;
        end
        if (w_ns == S_IDLE) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign txen        = r_txen;
  assign txd         = r_sh[DATA_W-1:0];
  assign busy        = r_busy;
  assign done        = r_done;
  assign frames_sent = r_frames;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_eth_frame_gen.sv
// Bench for eth_frame_gen: three instances (DATA_W 2, 4, 8) with byte capture,
// a table-driven run list, hand-written stop/reset sequences and random runs,
// all checked against a byte-level frame model with a table-driven CRC-32.
`timescale 1ns/1ps
module tb_eth_frame_gen;
  localparam int IFG = 12;
`ifdef ETH_GEN_VLAN_EN
  localparam int HLEN = 18;
  localparam int MINP = 42;
`else
  localparam int HLEN = 14;
  localparam int MINP = 46;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, start = 1'b0, start_w = 1'b0, stop = 1'b0, cap_clr = 1'b0;
  logic [15:0] count = 16'd0;
  logic [10:0] plen = 11'd0;
  logic [7:0]  seed = 8'd0;
  int checks = 0, failures = 0;
  logic [31:0] crc_tab[256];
  logic [2:0]  idle_dbg;

  // ---------------- DUTs and per-instance capture ----------------
  for (genvar g = 0; g < 3; g++) begin : g_i
    localparam int DW = 2 << g;
    logic          txen_w, busy_w, done_w, st_in, stop_in;
    logic [DW-1:0] txd_w;
    logic [15:0]   fs_w;
    logic [2:0]    st_w;
    assign st_in   = (g == 0) ? start : start_w;
    assign stop_in = (g == 0) ? stop : 1'b0;

    eth_frame_gen #(.DATA_W(DW), .VLAN_ID(12'h005)) u_dut (
      .clk_mac(clk), .rst(rst), .start(st_in), .stop(stop_in), .count(count),
      .payload_len(plen), .seed(seed), .txen(txen_w), .txd(txd_w), .busy(busy_w),
      .done(done_w), .frames_sent(fs_w), .dbg_state(st_w));

    logic [7:0] fb_q[$];
    int flen_q[$], fcyc_q[$], gap_q[$];
    int cur_cyc = 0, cur_bytes = 0, low_cyc = 0, done_cnt = 0, ifg_done = 0, nb = 0;
    bit prev_txen = 0, had_frame = 0;
    logic [7:0] acc = 8'h00;

    always @(negedge clk) begin
      if (cap_clr) begin
        fb_q.delete(); flen_q.delete(); fcyc_q.delete(); gap_q.delete();
        cur_cyc = 0; cur_bytes = 0; low_cyc = 0; done_cnt = 0; ifg_done = 0;
        nb = 0; prev_txen = 0; had_frame = 0; acc = 8'h00;
      end else begin
        if (txen_w) begin
          if (!prev_txen) begin
            if (had_frame) gap_q.push_back(low_cyc);
            cur_cyc = 0; cur_bytes = 0; nb = 0; acc = 8'h00;
          end
          acc = acc | (8'(txd_w) << (nb * DW));
          nb++;
          if (nb == 8 / DW) begin
            fb_q.push_back(acc); cur_bytes++; nb = 0; acc = 8'h00;
          end
          cur_cyc++;
        end else begin
          if (prev_txen) begin
            flen_q.push_back(cur_bytes); fcyc_q.push_back(cur_cyc);
            low_cyc = 0; had_frame = 1;
          end
          if (busy_w) low_cyc++;
        end
        if (done_w) begin
          done_cnt++; ifg_done = low_cyc;
        end
        prev_txen = txen_w;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    return crc_tab[(c ^ {24'h0, b}) & 32'hFF] ^ (c >> 8);
  endfunction

  function automatic int clampf(input int l);
    return (l < MINP) ? MINP : (l > 1500) ? 1500 : l;
  endfunction

  function automatic void model_frame(input int pl, input int sd, output logic [7:0] m[$]);
    logic [31:0] c;
    m.delete();
    for (int i = 0; i < 7; i++) m.push_back(8'h55);
    m.push_back(8'hD5);
    for (int i = 0; i < 6; i++) m.push_back(8'hFF);
    m.push_back(8'h00); m.push_back(8'h0A); m.push_back(8'h35);
    m.push_back(8'h00); m.push_back(8'h00); m.push_back(8'h01);
`ifdef ETH_GEN_VLAN_EN
    m.push_back(8'h81); m.push_back(8'h00); m.push_back(8'h00); m.push_back(8'h05);
`endif
    m.push_back(8'h88); m.push_back(8'hB5);
    for (int i = 0; i < pl; i++) m.push_back(8'((sd + i) % 256));
    c = 32'hFFFFFFFF;
    for (int i = 8; i < m.size(); i++) c = crc_upd(c, m[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) m.push_back(c[8*i +: 8]);
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic verify(input string tag, input int dw, input int exp_frames, input int pl,
                        input int sd, input int exp_cyc, input logic [7:0] fb[$],
                        input int fl[$], input int fc[$], input int gp[$],
                        input int dcnt, input int idone, input int fs);
    logic [7:0] exp_q[$];
    logic [31:0] r;
    int off, nmis;
    model_frame(pl, sd, exp_q);
    chk({tag, ":n_frames"}, fl.size(), exp_frames);
    off = 0;
    for (int f = 0; f < fl.size() && f < exp_frames; f++) begin
      chk({tag, ":frame_len"}, fl[f], exp_q.size());
      chk({tag, ":txen_cycles"}, fc[f], exp_cyc);
      nmis = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (off + i >= fb.size() || i >= fl[f]) nmis++;
        else if (fb[off + i] !== exp_q[i]) nmis++;
      end
      chk({tag, ":frame_bytes_mismatches"}, nmis, 0);
      r = 32'hFFFFFFFF;
      for (int i = 8; i < fl[f] && off + i < fb.size(); i++) r = crc_upd(r, fb[off + i]);
      chk({tag, ":crc_residue"}, r, 32'hDEBB20E3);
      off += fl[f];
    end
    chk({tag, ":n_gaps"}, gp.size(), exp_frames - 1);
    foreach (gp[i]) chk({tag, ":gap_cycles"}, gp[i], IFG * 8 / dw);
    chk({tag, ":done_pulses"}, dcnt, 1);
    chk({tag, ":ifg_before_done"}, idone, IFG * 8 / dw);
    chk({tag, ":frames_sent"}, fs, exp_frames);
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_cap();
    @(posedge clk); cap_clr = 1'b1;
    @(posedge clk); cap_clr = 1'b0;
  endtask

  task automatic pulse_start(input string tag, input int c, input int l, input int sd);
    @(negedge clk);
    count = 16'(c); plen = 11'(l); seed = 8'(sd); start = 1'b1;
    @(posedge clk); #1;
    chk({tag, ":first_txen"}, g_i[0].txen_w, 1);
    chk({tag, ":first_txd"}, g_i[0].txd_w, 2'b01);
    chk({tag, ":busy_after_start"}, g_i[0].busy_w, 1);
    chk({tag, ":state_left_idle"}, g_i[0].st_w != idle_dbg, 1);
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done0(input string tag);
    int n;
    n = 0;
    while (g_i[0].done_cnt == 0 && n < 30000) begin @(negedge clk); n++; end
    chk({tag, ":done_seen"}, g_i[0].done_cnt != 0, 1);
    repeat (3) @(negedge clk);
    chk({tag, ":busy_low_at_end"}, g_i[0].busy_w, 0);
  endtask

  task automatic run_main(input string tag, input int c, input int l, input int sd, input bit mid,
                          input int exp_frames, input int exp_cyc, input int pl);
    int n;
    clear_cap();
    pulse_start(tag, c, l, sd);
    if (mid) begin
      n = 0;
      while (g_i[0].flen_q.size() < 1 && n < 20000) begin @(negedge clk); n++; end
      repeat (60) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    wait_done0(tag);
    verify(tag, 2, exp_frames, pl, sd, exp_cyc, g_i[0].fb_q, g_i[0].flen_q, g_i[0].fcyc_q,
           g_i[0].gap_q, g_i[0].done_cnt, g_i[0].ifg_done, int'(g_i[0].fs_w));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int c; int l; int sd; bit mid; int exp_frames; int exp_cyc; int exp_pl;
  } vec_t;
  vec_t vecs[5];

  // ---------------- main sequence ----------------
  initial begin
    int n, c, l, sd, pl;
    for (int i = 0; i < 256; i++) begin
      logic [31:0] v;
      v = 32'(i);
      for (int k = 0; k < 8; k++) v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
      crc_tab[i] = v;
    end
`ifdef ETH_GEN_VLAN_EN
    vecs[0] = '{1, 46, 8'h00, 1'b0, 1, 304, 46};
    vecs[1] = '{1, 10, 8'h33, 1'b0, 1, 288, 42};
    vecs[2] = '{1, 1600, 8'h80, 1'b0, 1, 6120, 1500};
    vecs[3] = '{1, 100, 8'hF0, 1'b0, 1, 520, 100};
    vecs[4] = '{3, 46, 8'h11, 1'b1, 3, 304, 46};
`else
    vecs[0] = '{1, 46, 8'h00, 1'b0, 1, 288, 46};
    vecs[1] = '{1, 10, 8'h33, 1'b0, 1, 288, 46};
    vecs[2] = '{1, 1600, 8'h80, 1'b0, 1, 6104, 1500};
    vecs[3] = '{1, 100, 8'hF0, 1'b0, 1, 504, 100};
    vecs[4] = '{3, 46, 8'h11, 1'b1, 3, 288, 46};
`endif

    // reset state
    repeat (3) @(negedge clk);
    chk("reset:txen", g_i[0].txen_w, 0);
    chk("reset:txd", g_i[0].txd_w, 0);
    chk("reset:busy", g_i[0].busy_w, 0);
    chk("reset:done", g_i[0].done_w, 0);
    chk("reset:frames_sent", g_i[0].fs_w, 0);
    chk("reset:txen_w8", g_i[2].txen_w, 0);
    idle_dbg = g_i[0].st_w;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // table-driven runs
    foreach (vecs[v]) begin
      run_main($sformatf("vec%0d", v), vecs[v].c, vecs[v].l, vecs[v].sd, vecs[v].mid,
               vecs[v].exp_frames, vecs[v].exp_cyc, vecs[v].exp_pl);
    end

    // continuous run, stop raised at payload byte 20 of frame 2
    clear_cap();
    pulse_start("stop", 0, 46, 8'h42);
    n = 0;
    while (!(g_i[0].flen_q.size() == 1 &&
             g_i[0].fb_q.size() >= g_i[0].flen_q[0] + 8 + HLEN + 20) && n < 20000) begin
      @(negedge clk); n++;
    end
    chk("stop:reached_frame2", g_i[0].flen_q.size(), 1);
    stop = 1'b1;
    wait_done0("stop");
    stop = 1'b0;
    verify("stop", 2, 2, MINP > 46 ? MINP : 46, 8'h42, (8 + HLEN + 46 + 4) * 4, g_i[0].fb_q,
           g_i[0].flen_q, g_i[0].fcyc_q, g_i[0].gap_q, g_i[0].done_cnt, g_i[0].ifg_done,
           int'(g_i[0].fs_w));

    // reset during the FCS
    clear_cap();
    pulse_start("rst", 1, 46, 8'h07);
    n = 0;
    while (g_i[0].fb_q.size() < 8 + HLEN + 46 + 1 && n < 20000) begin @(negedge clk); n++; end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid:txen", g_i[0].txen_w, 0);
    chk("rst_mid:txd", g_i[0].txd_w, 0);
    chk("rst_mid:busy", g_i[0].busy_w, 0);
    chk("rst_mid:done", g_i[0].done_w, 0);
    chk("rst_mid:frames_sent", g_i[0].fs_w, 0);
    @(negedge clk); rst = 1'b0;
    run_main("after_rst", 1, 46, 8'h07, 1'b0, 1, (8 + HLEN + 46 + 4) * 4, 46);

    // random runs against the model
    for (int r = 0; r < 4; r++) begin
      c  = $urandom_range(1, 2);
      l  = $urandom_range(0, 260);
      sd = $urandom_range(0, 255);
      pl = clampf(l);
      run_main($sformatf("rand%0d", r), c, l, sd, 1'b0, c, (8 + HLEN + pl + 4) * 4, pl);
    end

    // width sweep: DATA_W 4 and 8, payload wrapping FF->00
    clear_cap();
    @(negedge clk);
    count = 16'd2; plen = 11'd100; seed = 8'hF0; start_w = 1'b1;
    @(negedge clk); start_w = 1'b0;
    n = 0;
    while ((g_i[1].done_cnt == 0 || g_i[2].done_cnt == 0) && n < 20000) begin
      @(negedge clk); n++;
    end
    chk("sweep:done_seen", g_i[1].done_cnt != 0 && g_i[2].done_cnt != 0, 1);
    repeat (3) @(negedge clk);
    verify("w4", 4, 2, 100, 8'hF0, (8 + HLEN + 104) * 2, g_i[1].fb_q, g_i[1].flen_q,
           g_i[1].fcyc_q, g_i[1].gap_q, g_i[1].done_cnt, g_i[1].ifg_done, int'(g_i[1].fs_w));
    verify("w8", 8, 2, 100, 8'hF0, 8 + HLEN + 104, g_i[2].fb_q, g_i[2].flen_q,
           g_i[2].fcyc_q, g_i[2].gap_q, g_i[2].done_cnt, g_i[2].ifg_done, int'(g_i[2].fs_w));
    if (g_i[2].fb_q.size() > 8 + HLEN + 16) begin
      chk("w8:payload_byte15", g_i[2].fb_q[8 + HLEN + 15], 8'hFF);
      chk("w8:payload_byte16", g_i[2].fb_q[8 + HLEN + 16], 8'h00);
    end else begin
      chk("w8:payload_present", g_i[2].fb_q.size(), 8 + HLEN + 17);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // watchdog
  initial begin
    #5ms;
    $display("FAIL watchdog simulation time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/eth_frame_gen.md
Name: eth_frame_gen

Overview:
Synthesizable, parametrised Ethernet frame generator for on-chip MAC/PHY bring-up and loopback tests. It replaces hand-built testbench frame sends.
- Emits complete frames on an xMII-style transmit interface: preamble, SFD, header, counting payload, FCS, inter-frame gap.
- Data width is selectable: RMII 2-bit, MII 4-bit or GMII 8-bit.
- Sits on clk_mac beside the MAC TX path and can drive the PHY pins or the MAC RX input directly.

Parameters:
DATA_W, 2, bits per txd beat; legal values 2, 4, 8; each byte takes 8/DATA_W beats, least-significant bits first.
IFG_BYTES, 12, idle byte-times between frames; minimum 12.
DST_MAC, 48'hFFFFFFFFFFFF, destination address, sent MSB byte first.
SRC_MAC, 48'h000A35000001, source address, sent MSB byte first.
ETHERTYPE, 16'h88B5, EtherType field, sent MSB byte first.
VLAN_ID, 12'd1, VID used only when ETH_GEN_VLAN_EN is defined.

Ports:
clk_mac  in  1  MAC clock; all logic on its rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; latches count, payload_len and seed.
stop  in  1  level; finish the current frame and IFG, then go idle.
count  in  16  frames to send; 0 means continuous until stop.
payload_len  in  11  payload bytes requested; clamped to 46..1500.
seed  in  8  value of the first payload byte.
txen  out  1  frame valid; high from the first preamble beat to the last FCS beat.
txd  out  DATA_W  transmit beat.
busy  out  1  high from the cycle after an accepted start until the last IFG beat.
done  out  1  one-cycle pulse on the beat where busy falls.
frames_sent  out  16  completed frames since the last accepted start; saturates at 16'hFFFF.

Behaviour:
Reset (rst=1 at an edge):
- txen=0, txd=0, busy=0, done=0, frames_sent=0, state=IDLE.
- Reset mid-frame truncates the frame immediately; there is no FCS and no IFG.

Start and input latching:
- start is accepted only in IDLE. start while busy is ignored.
- On the accepting edge: latch count, seed and clamped payload_len (values <46 become 46, >1500 become 1500); clear frames_sent.
- The first preamble beat appears on txd/txen 1 cycle after the start edge (latency 1).

Serializer:
- A byte register plus a beat counter (0..8/DATA_W-1).
- State advances only on the last beat of a byte; txd = byte[beat*DATA_W +: DATA_W].

States (byte counts):
- IDLE
- PREAMBLE: 7 x 0x55.
- SFD: 1 x 0xD5.
- HEADER: 14 bytes, DST_MAC, SRC_MAC, ETHERTYPE.
- PAYLOAD: payload_len bytes; byte i = (seed + i) mod 256, 8-bit wrap.
- FCS: 4 bytes.
- IFG: IFG_BYTES byte-times with txen=0, txd=0.

CRC:
- CRC-32, reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF.
- Updated per byte over HEADER+PAYLOAD, never over PREAMBLE/SFD.
- FCS = bitwise NOT of the CRC, sent least-significant byte first.
- Receiver residue over the full frame incl. FCS = 0xDEBB20E3.

Frame counting and IFG exit:
- frames_sent increments on the last FCS beat.
- At the end of IFG, return to IDLE and pulse done if any of these holds:
  - frames_sent == latched count and count != 0;
  - stop is high;
  - rst.
- Otherwise go straight to PREAMBLE; the payload restarts at seed for every frame.

stop handling:
- stop sampled in IDLE has no effect.
- stop asserted mid-frame never truncates the frame; the frame completes with a valid FCS.

Frame length: txen stays high for (8+14+payload_len+4)*8/DATA_W consecutive cycles.

Optional Feature:
ETH_GEN_VLAN_EN
- Defined: an 802.1Q tag is inserted after SRC_MAC: 0x8100 then {3'b000, 1'b0, VLAN_ID}. HEADER becomes 18 bytes and is covered by the CRC. Payload clamp minimum becomes 42.
- Undefined: the header is 14 bytes, with no tag logic or VLAN_ID use.

Test Plan:
1. DATA_W=2, count=1, payload_len=46, seed=0 -> txen high 288 cycles; first 28 dibits are 01; SFD dibits 01,01,01,11; payload bytes 00..2D; done 1 cycle after the 48-cycle IFG; frames_sent=1.
2. Bench CRC model on captured frames, for payload_len=100 and seed=8'hF0 -> payload wraps FF->00 at byte 16; residue over frame+FCS = 0xDEBB20E3; sweep DATA_W=2, 4 and 8.
3. payload_len=10, then payload_len=1600 -> 46 and 1500 payload bytes emitted respectively; txen high 288 and 6104 cycles respectively (DATA_W=2).
4. count=3 with a second start pulsed mid-run -> exactly 3 frames; second start ignored; txen low exactly 48 cycles between frames; frames_sent=3; single done pulse.
5. count=0, stop raised at payload byte 20 of frame 2 -> frame 2 completes with a valid FCS; IFG runs; idle; frames_sent=2.
6. rst asserted at FCS byte 1 -> next edge txen=0, busy=0, frames_sent=0; a fresh start sends a clean frame 1 cycle later.
7. ETH_GEN_VLAN_EN defined, VLAN_ID=12'h005 -> bytes 12..15 = 81 00 00 05; EtherType at bytes 16..17; FCS valid.
